// File: rtl/htd_if.sv
// Data-in / data-out bus for the htd frame tail detector.
// ov_data carries the tail flag in its top bit above the data word.
interface htd_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] iv_data;
  logic                  i_data_wr;
  logic [DATA_WIDTH:0]   ov_data;
  logic                  o_data_wr;

  modport master (
    output iv_data,
    output i_data_wr,
    input  ov_data,
    input  o_data_wr
  );

  modport slave (
    input  iv_data,
    input  i_data_wr,
    output ov_data,
    output o_data_wr
  );
endinterface

// File: rtl/htd.sv
// htd: marks the last word of each write burst with a tail flag, using a fixed 2-cycle registered latency.
// Defining HTD_MAXLEN_SPLIT_EN also forces a tail every MAX_FRAME_LEN words.
module htd #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 64
) (
  input  logic  i_clk,
  input  logic  i_rst,
  htd_if.slave  bus
);

  logic                  hold_v;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  tail;

  if (MAX_FRAME_LEN < 2 || MAX_FRAME_LEN > 65535) begin : g_bad_len
    $error("htd: MAX_FRAME_LEN must be in 2..65535");
  end

`ifdef HTD_MAXLEN_SPLIT_EN
  localparam int CW = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_FRAME_LEN - 1);

  logic [CW-1:0] word_cnt;

  // word_cnt counts the words of the current frame already emitted, so the
  // held word is the MAX_FRAME_LEN-th one when word_cnt reaches LAST_CNT.
  always_comb begin
    tail = ~bus.i_data_wr;
    if (word_cnt == LAST_CNT) begin
      tail = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_cnt <= '0;
    end else if (hold_v) begin
      word_cnt <= tail ? '0 : word_cnt + CW'(1);
    end
  end
`else
  always_comb begin
    tail = ~bus.i_data_wr;
  end
`endif

  // A held word becomes the tail when the write strobe drops in the cycle after it was captured.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_v        <= 1'b0;
      hold_data     <= '0;
      bus.o_data_wr <= 1'b0;
      bus.ov_data   <= '0;
    end else begin
      hold_v <= bus.i_data_wr;
      if (bus.i_data_wr) begin
        hold_data <= bus.iv_data;
      end
      bus.o_data_wr <= hold_v;
      bus.ov_data   <= hold_v ? {tail, hold_data} : '0;
    end
  end

endmodule

// File: tb/tb_htd.sv
// Scoreboard bench for htd: stimulus pushes hand-computed outputs with their due cycle,
// and a negedge monitor pops and compares them against whatever the DUT presents.
module tb_htd;

  localparam int DW = 8;
  localparam int ML = 4;

`ifdef HTD_MAXLEN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    logic [DW:0] val;
    int          cyc;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;
  exp_t sb[$];

  htd_if #(.DATA_WIDTH(DW)) bus ();

  htd #(
    .DATA_WIDTH    (DW),
    .MAX_FRAME_LEN (ML)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Drive one cycle of input; a pushed word is due on the output two cycles later.
  task automatic applyStimulus(input logic wr, input logic [DW-1:0] d,
                               input bit push, input logic [DW:0] ev);
    bus.i_data_wr = wr;
    bus.iv_data   = d;
    if (push) sb.push_back('{val: ev, cyc: cyc + 2});
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, DW'($urandom), 1'b0, '0);
    end
  endtask

  task automatic sendFrame(input logic [DW-1:0] first, input int n);
    logic [DW-1:0] d;
    logic          t;
    for (int i = 0; i < n; i++) begin
      d = first + DW'(i);
      t = (i == n - 1) || (SPLIT && ((i + 1) % ML == 0));
      applyStimulus(1'b1, d, 1'b1, {t, d});
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_output: expected %h due cycle %0d, nothing seen by cycle %0d",
               e.val, e.cyc, cyc);
    end
    checks++;
    if (bus.o_data_wr === 1'b1) begin
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: got %h at cycle %0d, expected no write",
                 bus.ov_data, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.ov_data !== e.val || e.cyc != cyc) begin
          errors++;
          $display("[TB] FAIL output_word: got %h at cycle %0d, expected %h at cycle %0d",
                   bus.ov_data, cyc, e.val, e.cyc);
        end
      end
    end else if (bus.o_data_wr !== 1'b0 || bus.ov_data !== '0) begin
      errors++;
      $display("[TB] FAIL idle_output: got wr=%b data=%h at cycle %0d, expected wr=0 data=000",
               bus.o_data_wr, bus.ov_data, cyc);
    end
  endtask

  always @(negedge i_clk) begin
    if (mon_on) checkOutput();
  end

  initial begin
    i_rst         = 1'b1;
    bus.i_data_wr = 1'b1;
    bus.iv_data   = 8'h55;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (bus.o_data_wr !== 1'b0 || bus.ov_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got wr=%b data=%h, expected wr=0 data=000",
               bus.o_data_wr, bus.ov_data);
    end
    i_rst         = 1'b0;
    bus.i_data_wr = 1'b0;
    mon_on        = 1'b1;
    idle(2);

    // Two 6-word frames separated by one idle cycle
    sendFrame(8'h01, 6);
    idle(1);
    sendFrame(8'h07, 6);
    idle(2);

    // Isolated single word, then idle with toggling data
    sendFrame(8'hA5, 1);
    idle(6);

    // Long uninterrupted burst
    sendFrame(8'h20, 20);
    idle(2);

    // Reset while 0x03 is held: it must vanish, and writes during reset are ignored
    applyStimulus(1'b1, 8'h01, 1'b1, 9'h001);
    applyStimulus(1'b1, 8'h02, 1'b1, 9'h002);
    applyStimulus(1'b1, 8'h03, 1'b0, '0);
    i_rst = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b0, '0);
    i_rst = 1'b0;
    idle(1);
    sendFrame(8'h10, 1);
    idle(4);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/htd.md
HTD -- requirements
Module: htd

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the input data word.
REQ-002 Parameter MAX_FRAME_LEN, default 64, maximum words per output frame (used only with HTD_MAXLEN_SPLIT_EN); legal range 2..65535.
REQ-003 i_clk  input  1  single clock; all logic on the rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 iv_data  input  DATA_WIDTH  input data word, valid when i_data_wr=1.
REQ-006 i_data_wr  input  1  input write strobe; one word per cycle while high.
REQ-007 ov_data  output  DATA_WIDTH+1  bit [DATA_WIDTH] is the tail flag; bits [DATA_WIDTH-1:0] are the data word.
REQ-008 o_data_wr  output  1  output write strobe; ov_data valid when high.

Function
REQ-009 A frame SHALL be a maximal run of consecutive cycles with i_data_wr=1; iv_data SHALL be ignored when i_data_wr=0.
REQ-010 Each accepted word SHALL first be captured in a one-word holding register (hold_data, hold_v) on the edge ending its input cycle N.
REQ-011 On the edge ending cycle N+1, if hold_v=1: o_data_wr<=1 and ov_data<={tail, hold_data}, where tail=1 if i_data_wr=0 in cycle N+1, else 0.
REQ-012 Latency SHALL be exactly 2 cycles: a word sampled in cycle N appears on ov_data/o_data_wr in cycle N+2.
REQ-013 Output SHALL be fully registered; no combinational path from inputs to outputs.
REQ-014 Words SHALL be output in input order, unmodified, with none dropped or duplicated; throughput one word per cycle.
REQ-015 If hold_v=0, o_data_wr SHALL be 0 and ov_data SHALL be all zeros in the next cycle.
REQ-016 A single-word frame SHALL be output with tail=1.
REQ-017 Exactly one word per frame SHALL carry tail=1: the last word.
REQ-018 Back-to-back frames separated by a single idle cycle SHALL be delimited correctly: the last word of the first frame has tail=1, the first word of the second has tail=0 (unless it is also its last).

Reset
REQ-019 While i_rst=1 at a rising edge: o_data_wr<=0, ov_data<=0, hold_v<=0, hold_data<=0, frame word counter<=0.
REQ-020 Reset mid-frame SHALL discard the held word without emitting it; after reset deasserts, the first accepted word starts a new frame.
REQ-021 i_data_wr during a reset cycle SHALL be ignored.

Configuration
REQ-022 Macro HTD_MAXLEN_SPLIT_EN, when defined, SHALL add a frame word counter (width ceil(log2(MAX_FRAME_LEN+1))); the word at count MAX_FRAME_LEN SHALL be output with tail=1 even if i_data_wr stays high, and the counter SHALL restart so the next word begins a new frame.
REQ-023 The counter SHALL reset to 0 at every tail (natural or forced) and on reset.
REQ-024 Without HTD_MAXLEN_SPLIT_EN, the counter SHALL not exist, frames SHALL be unbounded, and tail SHALL depend only on REQ-011.

Verification
REQ-025 Reset, then 6 words 0x01..0x06 on consecutive cycles, 1 idle cycle, 6 words 0x07..0x0C -> outputs 0x001..0x005, 0x106, then 0x007..0x00B, 0x10C, each 2 cycles after input, o_data_wr high for exactly 12 cycles.
REQ-026 Single word 0xA5 with idle before and after -> one output 0x1A5, o_data_wr one cycle.
REQ-027 Continuous 20 words with no gap (macro off) -> only the 20th word has bit 8 set.
REQ-028 Macro on, MAX_FRAME_LEN=4, 6 consecutive words 0x01..0x06 -> outputs 0x001,0x002,0x003,0x104,0x005,0x106.
REQ-029 Words 0x01..0x03, i_rst=1 for one cycle while 0x03 is held -> 0x03 never output; next word 0x10 alone -> 0x110.
REQ-030 i_data_wr=0 with iv_data toggling -> o_data_wr stays 0, ov_data stays 0x000.
